// File: rtl/audio_pkg.sv
// Shared audio types: 16-bit two's-complement samples and a packed stereo pair.
package audio_pkg;
  localparam int SAMPLE_BITS = 16;
  localparam int FRAME_BITS  = 32;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  // Packed so {l, r} lines up with the left-first serial frame.
  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
endpackage

// File: rtl/bclk_gen.sv
// Free-running I2S bit clock divider; flags the clk cycle on which bclk rises or falls.
module bclk_gen #(
  parameter int HALF_DIV = 24
) (
  input  logic clk,
  input  logic reset,
  output logic bclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          tick;

  assign tick = (div_cnt_q == CW'(HALF_DIV - 1));

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    bclk_d    = bclk_q ^ tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o      = bclk_q;
  assign rise_tick_o = tick & ~bclk_q;
  assign fall_tick_o = tick &  bclk_q;
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-deep sample holding register feeding a 32-bit frame shifter,
// with underrun/overrun pulses. All serial outputs change on bclk falling edges.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int HALF_DIV = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] data_l,
  input  logic [15:0] data_r,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        overrun
);
  logic rise_tick, fall_tick;

  bclk_gen #(.HALF_DIV(HALF_DIV)) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .bclk_o     (bclk),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick)
  );

  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] frame_sr_q, frame_sr_d;
  stereo_t               hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic [4:0]            n, sd_idx;
  logic                  load;

  // n is the post-increment bit count; bit 32-n wraps so n==0 picks the old right LSB.
  assign n      = bit_cnt_q + 5'd1;
  assign sd_idx = 5'd0 - n;
  assign load   = fall_tick && (n == 5'd0);

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    frame_sr_d   = frame_sr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    underrun_d   = load & ~hold_valid_q;
    overrun_d    = en & hold_valid_q & ~load;
    if (fall_tick) begin
      bit_cnt_d = n;
      lrclk_d   = n[4];
      sdata_d   = frame_sr_q[sd_idx];
    end
    if (load) begin
      frame_sr_d   = hold_q;
      hold_valid_d = 1'b0;
    end
    // A strobe on the load cycle lands in hold after the old contents were taken.
    if (en) begin
      hold_d.l     = data_l;
      hold_d.r     = data_r;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      frame_sr_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      frame_sr_q   <= frame_sr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

  a_edges_exclusive: assert property (@(posedge clk) disable iff (reset) !(rise_tick && fall_tick));
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at HALF_DIV=2: every clk compares all outputs against a waveform model
// derived from clk count since reset release and a log of accepted en strobes.
module tb_i2s_tx;
  localparam int HD    = 2;
  localparam int FRAME = 64 * HD;

  logic        clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [15:0] data_l = '0, data_r = '0;
  logic        bclk, lrclk, sdata, underrun, overrun;

  i2s_tx #(.HALF_DIV(HD)) dut (
    .clk(clk), .reset(reset), .en(en), .data_l(data_l), .data_r(data_r),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          k;
  int          checks = 0, errors = 0;
  int          ek[$];
  logic [15:0] el[$], er[$];

  // Frame f (loaded at clk f*FRAME) carries the newest sample strobed strictly before that clk.
  function automatic logic [31:0] frame_word(int f);
    logic [31:0] w = '0;
    for (int i = 0; i < ek.size(); i++)
      if (ek[i] < f * FRAME) w = {el[i], er[i]};
    return w;
  endfunction

  // Expected {bclk, lrclk, sdata, underrun, overrun} just after clk kk.
  function automatic logic [4:0] exp_out(int kk);
    int f, b, fr;
    logic [31:0] w;
    logic bc, lr, sd, ur, ov;
    if (kk == 0) return 5'b0;
    bc = ((kk / HD) % 2) == 1;
    f  = kk / (2 * HD);
    b  = f % 32;
    fr = f / 32;
    lr = (b >= 16);
    if (b == 0) begin
      w  = (fr == 0) ? 32'h0 : frame_word(fr - 1);
      sd = w[0];
    end else begin
      w  = frame_word(fr);
      sd = w[32 - b];
    end
    ur = 1'b0;
    if (kk % FRAME == 0) begin
      ur = 1'b1;
      for (int i = 0; i < ek.size(); i++)
        if (ek[i] / FRAME == kk / FRAME - 1) ur = 1'b0;
    end
    ov = 1'b0;
    for (int i = 0; i < ek.size(); i++)
      for (int j = 0; j < i; j++)
        if (ek[i] == kk && ek[j] / FRAME == kk / FRAME) ov = 1'b1;
    return {bc, lr, sd, ur, ov};
  endfunction

  task automatic cycle(input logic e, input logic [15:0] l, input logic [15:0] r);
    en = e; data_l = l; data_r = r;
    @(posedge clk);
    k++;
    if (e) begin ek.push_back(k); el.push_back(l); er.push_back(r); end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic clear_model();
    k = 0;
    ek.delete(); el.delete(); er.delete();
  endtask

  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {bclk, lrclk, sdata, underrun, overrun};
    checks++;
    if (got !== 5'b0) begin errors++; $display("FAIL reset_state got=%b exp=00000", got); end
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_idle();
    logic [4:0] got, exp;
    while (k < 300) begin
      cycle(1'b0, 16'h0, 16'h0);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL idle k=%0d got=%b exp=%b", k, got, exp); end
    end
  endtask

  task automatic test_single();
    logic [4:0] got, exp;
    while (k < 540) begin
      cycle(k + 1 == 374, 16'hA55A, 16'h0F01);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL single k=%0d got=%b exp=%b", k, got, exp); end
    end
  endtask

  task automatic test_overrun();
    logic [4:0] got, exp;
    logic first;
    while (k < 790) begin
      first = (k + 1 == 600);
      cycle(first || (k + 1 == 620), first ? 16'h8000 : 16'h1234, first ? 16'h7FFF : 16'h4321);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL overrun k=%0d got=%b exp=%b", k, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    logic first;
    while (k < 1300) begin
      first = (k + 1 == 1014);
      cycle(first || (k + 1 == 1024), first ? 16'h1111 : 16'h0001, first ? 16'h2222 : 16'hFFFF);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL load_coincident k=%0d got=%b exp=%b", k, got, exp); end
    end
  endtask

  task automatic test_underrun_repeat();
    logic [4:0] got, exp;
    while (k < 1812) begin
      cycle(k + 1 == 1398, 16'h7FFF, 16'h8000);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL repeat k=%0d got=%b exp=%b", k, got, exp); end
    end
  endtask

  task automatic test_random();
    logic [4:0]  got, exp;
    logic [15:0] l0, r0, l1, r1;
    int          w0, p0, p1, ne;
    for (int w = 0; w < 8; w++) begin
      w0 = (k / FRAME + 1) * FRAME;
      ne = $urandom_range(0, 2);
      p0 = (ne > 0) ? w0 + $urandom_range(0, FRAME - 1) : -1;
      p1 = (ne > 1) ? w0 + $urandom_range(0, FRAME - 1) : -1;
      l0 = 16'($urandom); r0 = 16'($urandom); l1 = 16'($urandom); r1 = 16'($urandom);
      while (k < w0 + FRAME - 1) begin
        cycle((k + 1 == p0) || (k + 1 == p1), (k + 1 == p0) ? l0 : l1, (k + 1 == p0) ? r0 : r1);
        got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
        if (got !== exp) begin errors++; $display("FAIL random k=%0d got=%b exp=%b", k, got, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0]  got, exp;
    logic [15:0] l0, r0;
    while (((k / (2 * HD)) % 32) != 20) begin
      cycle(1'b0, 16'h0, 16'h0);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL pre_reset k=%0d got=%b exp=%b", k, got, exp); end
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    got = {bclk, lrclk, sdata, underrun, overrun}; checks++;
    if (got !== 5'b0) begin errors++; $display("FAIL reset_mid got=%b exp=00000", got); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    l0 = 16'($urandom); r0 = 16'($urandom);
    while (k < 3 * FRAME + 20) begin
      cycle(k + 1 == FRAME - 10, l0, r0);
      got = {bclk, lrclk, sdata, underrun, overrun}; exp = exp_out(k); checks++;
      if (got !== exp) begin errors++; $display("FAIL post_reset k=%0d got=%b exp=%b", k, got, exp); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_single();
    test_overrun();
    test_back_to_back();
    test_underrun_repeat();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
